// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control unit: a Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB
// over a req/ready memory port, with multi-cycle mul, trap reporting and a retire counter.
module multicycle_control #(
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             branch_eq,
  input  logic             branch_lt,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_req,
  output logic             mem_write,
  output logic [2:0]       imm_sel,
  output logic             reg_write,
  output logic             branch_unsigned,
  output logic             a_sel,
  output logic             b_sel,
  output logic [3:0]       alu_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_I, K_LOAD, K_STORE, K_JALR, K_JAL, K_BRANCH, K_NOP, K_HALT, K_ILL
  } kind_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_NOP   = 7'b0001111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;

  // One counter serves both the memory wait and the mul hold; it clears on every state entry.
  localparam int CNT_MAX = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
  localparam int WC_W    = $clog2(CNT_MAX + 1);
  localparam logic [WC_W-1:0] MEM_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] MUL_LAST = WC_W'(MUL_CYCLES - 1);

  // Returns {legal, alu_sel}; non-ALU opcodes add, unknown opcodes are illegal.
  function automatic logic [4:0] alu_decode(input logic [31:0] i);
    logic [4:0] r;
    r = {1'b0, 4'b0010};
    case (i[6:0])
      OP_R: begin
        case ({i[31:25], i[14:12]})
          10'b0000000_000: r = {1'b1, 4'b0010};
          10'b0100000_000: r = {1'b1, 4'b0110};
          10'b0000001_000: r = {1'b1, 4'b1100};
          10'b0000000_111: r = {1'b1, 4'b0000};
          10'b0000000_110: r = {1'b1, 4'b0001};
          10'b0000000_001: r = {1'b1, 4'b0111};
          default:         r = {1'b0, 4'b0010};
        endcase
      end
      OP_I: begin
        case (i[14:12])
          3'b000:  r = {1'b1, 4'b0010};
          3'b111:  r = {1'b1, 4'b0000};
          3'b110:  r = {1'b1, 4'b0001};
          3'b001:  r = {(i[31:25] == 7'b0000000), 4'b0111};
          default: r = {1'b0, 4'b0010};
        endcase
      end
      OP_BR:                                      r = {(i[14:13] != 2'b01), 4'b0010};
      OP_LOAD, OP_STORE, OP_JALR, OP_JAL, OP_NOP, OP_HALT: r = {1'b1, 4'b0010};
      default:                                    r = {1'b0, 4'b0010};
    endcase
    return r;
  endfunction

  function automatic kind_t classify(input logic [31:0] i, input logic legal);
    kind_t k;
    case (i[6:0])
      OP_R:     k = K_R;
      OP_I:     k = K_I;
      OP_LOAD:  k = K_LOAD;
      OP_STORE: k = K_STORE;
      OP_JALR:  k = K_JALR;
      OP_JAL:   k = K_JAL;
      OP_BR:    k = K_BRANCH;
      OP_NOP:   k = K_NOP;
      OP_HALT:  k = K_HALT;
      default:  k = K_ILL;
    endcase
    return legal ? k : K_ILL;
  endfunction

  state_t           state_r;
  logic [WC_W-1:0]  cnt_r;
  logic [CNT_W-1:0] retired_r;
  logic             halted_r;
  logic             trap_r;
  logic [1:0]       cause_r;

  logic [4:0] dec_s;
  kind_t      kind_s;
  logic [3:0] alu_code_s;
  logic       is_mul_s;
  logic       is_jump_s;
  logic       taken_s;
  logic [2:0] setup_imm_s;
  logic       setup_a_s;
  logic       setup_b_s;
  logic       unused_s;

  assign dec_s      = alu_decode(inst);
  assign kind_s     = classify(inst, dec_s[4]);
  assign alu_code_s = dec_s[3:0];
  assign is_mul_s   = (kind_s == K_R) && (alu_code_s == 4'b1100);
  assign is_jump_s  = (kind_s == K_JAL) || (kind_s == K_JALR);
  // funct3[2] picks lt over eq, funct3[0] inverts the sense.
  assign taken_s    = inst[12] ^ (inst[14] ? branch_lt : branch_eq);
  assign setup_a_s  = (kind_s == K_JAL) || (kind_s == K_BRANCH);
  assign setup_b_s  = (kind_s != K_R);
  assign unused_s   = ^{inst[24:15], inst[11:7]};

  // Immediate format selection by instruction class.
  always_comb begin
    setup_imm_s = 3'b000;
    case (kind_s)
      K_LOAD:   setup_imm_s = 3'b001;
      K_STORE:  setup_imm_s = 3'b010;
      K_JALR:   setup_imm_s = 3'b011;
      K_JAL:    setup_imm_s = 3'b100;
      K_BRANCH: setup_imm_s = 3'b110;
      default:  setup_imm_s = 3'b000;
    endcase
  end

  // Moore decode of control strobes from the state register and inst.
  always_comb begin
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    ir_write        = 1'b0;
    iord            = 1'b0;
    mem_req         = 1'b0;
    mem_write       = 1'b0;
    imm_sel         = 3'b000;
    reg_write       = 1'b0;
    branch_unsigned = 1'b0;
    a_sel           = 1'b0;
    b_sel           = 1'b1;
    alu_sel         = 4'b0010;
    wb_sel          = 2'b00;
    case (state_r)
      S_BOOT: begin
        b_sel   = 1'b0;
        alu_sel = 4'b0000;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: pc_write = (kind_s == K_NOP);
      S_EXEC: begin
        imm_sel         = setup_imm_s;
        a_sel           = setup_a_s;
        b_sel           = setup_b_s;
        alu_sel         = alu_code_s;
        branch_unsigned = (kind_s == K_BRANCH) & inst[13];
        pc_write        = (kind_s == K_BRANCH);
        pc_src          = (kind_s == K_BRANCH) & taken_s;
      end
      S_MEM: begin
        imm_sel   = setup_imm_s;
        a_sel     = setup_a_s;
        b_sel     = setup_b_s;
        alu_sel   = alu_code_s;
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = (kind_s == K_STORE);
        pc_write  = (kind_s == K_STORE) & mem_ready;
      end
      S_WB: begin
        imm_sel   = setup_imm_s;
        a_sel     = setup_a_s;
        b_sel     = setup_b_s;
        alu_sel   = alu_code_s;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = is_jump_s;
        wb_sel    = (kind_s == K_LOAD) ? 2'b00 : (is_jump_s ? 2'b10 : 2'b01);
      end
      default: pc_write = 1'b0;
    endcase
  end

  // State sequencing, wait/mul counter, sticky status flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_BOOT;
      cnt_r     <= '0;
      retired_r <= '0;
      halted_r  <= 1'b0;
      trap_r    <= 1'b0;
      cause_r   <= 2'b00;
    end else begin
      if (pc_write) begin
        retired_r <= retired_r + CNT_W'(1);
      end
      case (state_r)
        S_BOOT: begin
          state_r <= S_FETCH;
          cnt_r   <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_r <= S_DECODE;
            cnt_r   <= '0;
          end else if (cnt_r == MEM_LAST) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b10;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + WC_W'(1);
          end
        end
        S_DECODE: begin
          cnt_r <= '0;
          case (kind_s)
            K_HALT: begin
              state_r  <= S_HALT;
              halted_r <= 1'b1;
            end
            K_ILL: begin
              state_r <= S_TRAP;
              trap_r  <= 1'b1;
              cause_r <= 2'b01;
            end
            K_NOP:   state_r <= S_FETCH;
            default: state_r <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (is_mul_s && (cnt_r != MUL_LAST)) begin
            cnt_r <= cnt_r + WC_W'(1);
          end else begin
            cnt_r <= '0;
            if (kind_s == K_BRANCH) begin
              state_r <= S_FETCH;
            end else if ((kind_s == K_LOAD) || (kind_s == K_STORE)) begin
              state_r <= S_MEM;
            end else begin
              state_r <= S_WB;
            end
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_r <= (kind_s == K_LOAD) ? S_WB : S_FETCH;
            cnt_r   <= '0;
          end else if (cnt_r == MEM_LAST) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= 2'b11;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + WC_W'(1);
          end
        end
        S_WB: begin
          state_r <= S_FETCH;
          cnt_r   <= '0;
        end
        S_HALT:  state_r <= S_HALT;
        S_TRAP:  state_r <= S_TRAP;
        default: state_r <= S_BOOT;
      endcase
    end
  end

  assign halted     = halted_r;
  assign trap       = trap_r;
  assign trap_cause = cause_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a transaction-level model expands each
// instruction into expected per-cycle control bundles; a monitor compares every cycle.
module tb_multicycle_control;

  localparam int MUL_CYCLES  = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_JALR = 4, K_JAL = 5,
                 K_BR = 6, K_NOP = 7, K_HALT = 8, K_ILL = 9;

  logic clk = 1'b0;
  logic rst_n, branch_eq, branch_lt, mem_ready;
  logic [31:0] inst;
  logic pc_write, pc_src, ir_write, iord, mem_req, mem_write, reg_write;
  logic branch_unsigned, a_sel, b_sel, halted, trap;
  logic [2:0] imm_sel;
  logic [3:0] alu_sel;
  logic [1:0] wb_sel, trap_cause;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.MUL_CYCLES(MUL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .branch_eq(branch_eq), .branch_lt(branch_lt),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_req(mem_req), .mem_write(mem_write), .imm_sel(imm_sel),
    .reg_write(reg_write), .branch_unsigned(branch_unsigned), .a_sel(a_sel), .b_sel(b_sel),
    .alu_sel(alu_sel), .wb_sel(wb_sel), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  typedef struct packed {
    logic pc_write, pc_src, ir_write, iord, mem_req, mem_write;
    logic [2:0] imm_sel;
    logic reg_write, branch_unsigned, a_sel, b_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
    logic halted, trap;
    logic [1:0] trap_cause;
    logic [CNT_W-1:0] retired;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] m_retired;
  logic m_halted, m_trap;
  logic [1:0] m_cause;

  function automatic obs_t zero_obs();
    obs_t z;
    z = '0;
    return z;
  endfunction

  function automatic obs_t idle();
    obs_t e;
    e = '0;
    e.alu_sel = 4'b0010;
    e.b_sel = 1'b1;
    e.halted = m_halted;
    e.trap = m_trap;
    e.trap_cause = m_cause;
    e.retired = m_retired;
    return e;
  endfunction

  // ALU code for an instruction, or -1 if its funct fields are not supported.
  function automatic int alu_of(input logic [31:0] i);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    if (i[6:0] == 7'b0110011) begin
      if (f7 == 7'h00 && f3 == 3'd0) return 2;
      if (f7 == 7'h20 && f3 == 3'd0) return 6;
      if (f7 == 7'h01 && f3 == 3'd0) return 12;
      if (f7 == 7'h00 && f3 == 3'd7) return 0;
      if (f7 == 7'h00 && f3 == 3'd6) return 1;
      if (f7 == 7'h00 && f3 == 3'd1) return 7;
      return -1;
    end
    if (i[6:0] == 7'b0010011) begin
      if (f3 == 3'd0) return 2;
      if (f3 == 3'd7) return 0;
      if (f3 == 3'd6) return 1;
      if (f3 == 3'd1 && f7 == 7'h00) return 7;
      return -1;
    end
    return 2;
  endfunction

  function automatic int kind_of(input logic [31:0] i);
    int k;
    case (i[6:0])
      7'b0110011: k = K_R;
      7'b0010011: k = K_I;
      7'b0000011: k = K_LOAD;
      7'b0100011: k = K_STORE;
      7'b1100111: k = K_JALR;
      7'b1101111: k = K_JAL;
      7'b1100011: k = (i[14:12] == 3'd2 || i[14:12] == 3'd3) ? K_ILL : K_BR;
      7'b0001111: k = K_NOP;
      7'b1111111: k = K_HALT;
      default:    k = K_ILL;
    endcase
    if ((k == K_R || k == K_I) && alu_of(i) < 0) k = K_ILL;
    return k;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      default:    return !lt;
    endcase
  endfunction

  function automatic obs_t alu_fields(input obs_t e0, input logic [31:0] i, input int k);
    obs_t e;
    e = e0;
    e.alu_sel = 4'(alu_of(i));
    e.b_sel = (k != K_R);
    e.a_sel = (k == K_JAL || k == K_BR);
    e.imm_sel = (k == K_LOAD) ? 3'b001 : (k == K_STORE) ? 3'b010 : (k == K_JALR) ? 3'b011 :
                (k == K_JAL) ? 3'b100 : (k == K_BR) ? 3'b110 : 3'b000;
    return e;
  endfunction

  task automatic cyc(input obs_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    m_retired = '0;
    m_halted = 1'b0;
    m_trap = 1'b0;
    m_cause = 2'b00;
    cyc(zero_obs(), "reset");
    cyc(zero_obs(), "reset");
    rst_n = 1'b1;
    cyc(zero_obs(), "boot");
  endtask

  task automatic terminal(input string nm);
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) cyc(idle(), nm);
    mem_ready = 1'b0;
  endtask

  // Expands one instruction into its expected cycle sequence while driving ready/branch inputs.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic eq, input logic lt, input bit abort_mem);
    obs_t e;
    int k, n;
    inst = ins;
    branch_eq = eq;
    branch_lt = lt;
    k = kind_of(ins);
    for (int c = 0; c <= fw; c++) begin
      mem_ready = (c == fw);
      e = idle();
      e.mem_req = 1'b1;
      e.ir_write = (c == fw);
      cyc(e, "fetch");
      if (c != fw && c == MEM_TIMEOUT - 1) begin
        m_trap = 1'b1;
        m_cause = 2'b10;
        terminal("fetch_timeout");
        return;
      end
    end
    mem_ready = 1'b0;
    e = idle();
    e.pc_write = (k == K_NOP);
    cyc(e, "decode");
    if (k == K_HALT) begin
      m_halted = 1'b1;
      terminal("halt");
      return;
    end
    if (k == K_ILL) begin
      m_trap = 1'b1;
      m_cause = 2'b01;
      terminal("illegal");
      return;
    end
    if (k == K_NOP) begin
      m_retired = m_retired + CNT_W'(1);
      return;
    end
    n = (k == K_R && alu_of(ins) == 12) ? MUL_CYCLES : 1;
    for (int c = 0; c < n; c++) begin
      e = alu_fields(idle(), ins, k);
      if (k == K_BR) begin
        e.branch_unsigned = ins[13];
        e.pc_write = 1'b1;
        e.pc_src = taken(ins[14:12], eq, lt);
      end
      cyc(e, "exec");
    end
    if (k == K_BR) begin
      m_retired = m_retired + CNT_W'(1);
      return;
    end
    if (k == K_LOAD || k == K_STORE) begin
      for (int c = 0; c <= mw; c++) begin
        mem_ready = (c == mw);
        e = alu_fields(idle(), ins, k);
        e.mem_req = 1'b1;
        e.iord = 1'b1;
        e.mem_write = (k == K_STORE);
        e.pc_write = (k == K_STORE) && (c == mw);
        cyc(e, "mem");
        if (abort_mem) begin
          do_reset();
          return;
        end
        if (c != mw && c == MEM_TIMEOUT - 1) begin
          m_trap = 1'b1;
          m_cause = 2'b11;
          terminal("mem_timeout");
          return;
        end
      end
      mem_ready = 1'b0;
      if (k == K_STORE) begin
        m_retired = m_retired + CNT_W'(1);
        return;
      end
    end
    e = alu_fields(idle(), ins, k);
    e.reg_write = 1'b1;
    e.pc_write = 1'b1;
    e.pc_src = (k == K_JAL || k == K_JALR);
    e.wb_sel = (k == K_LOAD) ? 2'd0 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd1;
    cyc(e, "wb");
    m_retired = m_retired + CNT_W'(1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
    logic [2:0] f3;
    rd = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    f3 = 3'($urandom);
    case ($urandom_range(0, 13))
      0:  return {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
      1:  return {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011};
      2:  return {7'h01, rs2, rs1, 3'd0, rd, 7'b0110011};
      3:  return {7'($urandom_range(0, 1)), rs2, rs1, f3, rd, 7'b0110011};
      4:  return {imm, rs1, 3'd0, rd, 7'b0010011};
      5:  return {imm, rs1, f3, rd, 7'b0010011};
      6:  return {imm, rs1, 3'd2, rd, 7'b0000011};
      7:  return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
      8:  return {imm, rs1, rs2[2:0], rd, 7'b1101111};
      9:  return {imm, rs1, 3'd0, rd, 7'b1100111};
      10: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
      11: return {imm, rs1, f3, rd, 7'b0001111};
      12: return {imm, rs1, f3, rd, 7'($urandom)};
      default: return {imm, rs1, f3, rd, 7'b1111111};
    endcase
  endfunction

  // Monitor: pops one expected bundle per cycle and compares it against the DUT.
  initial begin
    forever begin
      obs_t a, e;
      string n;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {pc_write, pc_src, ir_write, iord, mem_req, mem_write, imm_sel, reg_write,
             branch_unsigned, a_sel, b_sel, alu_sel, wb_sel, halted, trap, trap_cause, retired};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    inst = 32'h0000_0000;
    branch_eq = 1'b0;
    branch_lt = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_instr({7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 0, 0, 1'b0, 1'b0, 1'b0); // add
    run_instr({7'h01, 5'd5, 5'd4, 3'd0, 5'd6, 7'b0110011}, 1, 0, 1'b0, 1'b0, 1'b0); // mul
    run_instr({7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'b1100011}, 0, 0, 1'b0, 1'b1, 1'b0); // bltu taken
    run_instr({7'h00, 5'd2, 5'd1, 3'd6, 5'd8, 7'b1100011}, 0, 0, 1'b1, 1'b0, 1'b0); // bltu not taken
    run_instr({12'h010, 5'd2, 3'd2, 5'd7, 7'b0000011}, 0, 3, 1'b0, 1'b0, 1'b0);      // lw, 3 wait
    run_instr({7'h00, 5'd9, 5'd2, 3'd2, 5'd4, 7'b0100011}, 2, 1, 1'b0, 1'b0, 1'b0); // sw
    run_instr({12'h123, 5'd0, 3'd0, 5'd1, 7'b1101111}, 0, 0, 1'b0, 1'b0, 1'b0);     // jal
    run_instr({12'h004, 5'd1, 3'd0, 5'd0, 7'b1100111}, 0, 0, 1'b0, 1'b0, 1'b0);     // jalr
    run_instr({12'h000, 5'd0, 3'd0, 5'd0, 7'b0001111}, 0, 0, 1'b0, 1'b0, 1'b0);     // nop
    run_instr({7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011}, 0, 0, 1'b1, 1'b0, 1'b0); // beq taken
    run_instr({12'h010, 5'd2, 3'd2, 5'd7, 7'b0000011}, 0, 5, 1'b0, 1'b0, 1'b1);     // reset mid-MEM
    run_instr({7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr({7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 20, 0, 1'b0, 1'b0, 1'b0); // fetch timeout
    do_reset();
    run_instr({12'h010, 5'd2, 3'd2, 5'd7, 7'b0000011}, 0, 20, 1'b0, 1'b0, 1'b0);    // data timeout
    do_reset();
    run_instr({7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr({7'h21, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011}, 0, 0, 1'b0, 1'b0, 1'b0); // illegal funct7
    do_reset();
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b0);                              // halt
    do_reset();
    for (int t = 0; t < 200; t++) begin
      int fw, mw;
      fw = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3);
      run_instr(rand_inst(), fw, mw, 1'($urandom), 1'($urandom), 1'b0);
      if (m_halted || m_trap) do_reset();
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation control unit for the RV32 datapath. It replaces the single-cycle combinational decoder with a Moore FSM that sequences FETCH/DECODE/EXEC/MEM/WB.
- It talks to a shared instruction/data memory over a req/ready handshake and supports a multi-cycle multiply.
- It adds unsigned branches, trap reporting on illegal instructions and memory timeouts, and a retired-instruction counter.
- It sits between the instruction register / branch comparator and the datapath muxes, regfile, PC and memory port.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles held for mul (min 1).
- MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before trapping (min 1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst  in  32  current instruction from the IR, valid from DECODE onward.
- branch_eq  in  1  rs1==rs2 from the comparator.
- branch_lt  in  1  rs1<rs2, signed/unsigned per branch_unsigned.
- mem_ready  in  1  memory completes the current request this cycle.
- pc_write  out  1  PC load strobe.
- pc_src  out  1  0: PC+4, 1: ALU result.
- ir_write  out  1  IR load strobe.
- iord  out  1  memory address select, 0: PC, 1: ALU result.
- mem_req  out  1  memory request.
- mem_write  out  1  store when mem_req=1.
- imm_sel  out  3  000 I-alu, 001 load, 010 store, 011 jalr, 100 jal, 110 branch.
- reg_write  out  1  regfile write strobe.
- branch_unsigned  out  1  comparator mode.
- a_sel  out  1  ALU A, 0: rs1, 1: PC.
- b_sel  out  1  ALU B, 0: rs2, 1: immediate.
- alu_sel  out  4  0010 add, 0110 sub, 1100 mul, 0000 and, 0001 or, 0111 sll.
- wb_sel  out  2  0: memory, 1: ALU, 2: PC+4.
- halted  out  1  sticky, set on the halt opcode.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 illegal opcode/funct, 10 fetch timeout, 11 data timeout.
- retired  out  CNT_W  count of completed instructions, wraps.

Behaviour:
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Outputs are decoded from the state register plus inst only; there are no combinational paths from mem_ready or branch_* except where noted below.
- Defaults in every state: all strobes 0, alu_sel=0010, b_sel=1, a_sel=0.
- Reset (asynchronous, rst_n=0): state=BOOT, all outputs 0, retired=0, halted=0, trap=0, trap_cause=00, wait counter=0. A reset mid-instruction abandons the instruction immediately.
- BOOT: outputs 0; goes to FETCH on the next edge.
- FETCH: mem_req=1, iord=0.
  - mem_ready=1: ir_write=1 combinationally in that cycle, then DECODE.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT with no ready: TRAP, cause 10.
  - The counter clears on every state entry.
- DECODE (1 cycle): classifies inst[6:0].
  - Opcode 1111111: HALT.
  - Opcode 0001111 (nop): pc_write=1, pc_src=0, retire, then FETCH.
  - Unknown opcode, unknown R/I funct3/funct7, or branch funct3 010/011: TRAP, cause 01. No strobes are issued.
  - Anything else: EXEC.
- EXEC:
  - imm_sel, a_sel, b_sel and alu_sel follow the opcode: R uses b_sel=0; jal and branch use a_sel=1; loads, stores, jalr and branches use add.
  - Branch: branch_unsigned=funct3[1]. pc_write=1, pc_src = beq:eq, bne:~eq, blt/bltu:lt, bge/bgeu:~lt (combinational from branch_*). Retire, then FETCH.
  - mul (funct7=0000001, funct3=000): stays in EXEC for exactly MUL_CYCLES cycles with alu_sel=1100, then WB.
  - Load/store: MEM. All other instructions: WB.
- MEM: mem_req=1, iord=1, mem_write=1 for stores, imm_sel and ALU inputs held.
  - On mem_ready, a load goes to WB.
  - On mem_ready, a store asserts pc_write=1, pc_src=0, retires, then FETCH.
  - Timeout works as in FETCH, cause 11.
- WB: reg_write=1, pc_write=1, then FETCH, retire.
  - wb_sel: load 0, R/I 1, jal/jalr 2.
  - pc_src: 1 for jal/jalr, else 0.
  - ALU inputs are held so the jump target stays valid.
- Retire: retired increments by 1 on the edge ending any cycle with pc_write=1. It wraps from 2^CNT_W-1 to 0.
- HALT: halted=1. Terminal until reset; no strobes; the instruction does not retire.
- TRAP: trap=1 and trap_cause latched on entry. Terminal until reset; no strobes.
- Clean traps: every memory access completes with at most one mem_req-high cycle per ready, and a trap never issues reg_write or pc_write.

Test Plan:
- rst_n low mid-MEM, release -> all outputs 0 in BOOT, FETCH one cycle later, retired=0.
- add x1,x2,x3 with mem_ready on the first FETCH cycle -> FETCH, DECODE, EXEC(b_sel=0, alu 0010), WB(reg_write=1, wb_sel=1, pc_write=1, pc_src=0) = 4 cycles; retired 0->1.
- mul with MUL_CYCLES=4 -> exactly 4 EXEC cycles with alu_sel=1100, then WB; total 7 cycles.
- bltu (funct3=110) with branch_lt=1 -> EXEC shows branch_unsigned=1, pc_src=1, pc_write=1; same instruction with branch_lt=0 -> pc_src=0.
- lw with mem_ready held low 3 cycles in MEM -> mem_req=1, iord=1 for 4 cycles, then WB with wb_sel=0, reg_write=1.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=15 -> TRAP after 15 cycles, trap=1, trap_cause=10.
- Opcode 0110011 funct7=0100001 -> TRAP cause 01, no reg_write, retired unchanged.
- Opcode 1111111 -> halted=1, PC frozen.
